// File: rtl/serial_add_sched_pkg.sv
// Shared definitions for the bit-serial adder scheduler: default operand width,
// FSM state encoding and the counter-width helper.
package serial_add_sched_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A one-bit operand still needs a one-bit counter register.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_add_sched_full_adder.sv
// Single-bit full adder; the only arithmetic element of the serial adder.
module Full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sched.sv
// Two-requester round-robin scheduler feeding one bit-serial adder; each accepted
// operation is summed LSB first over DATA_WIDTH cycles and held until consumed.
module serial_add_sched
    import serial_add_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    input  logic [DATA_WIDTH-1:0] i_req0_a,
    input  logic [DATA_WIDTH-1:0] i_req0_b,
    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    input  logic [DATA_WIDTH-1:0] i_req1_a,
    input  logic [DATA_WIDTH-1:0] i_req1_b,
    output logic                  o_sum_valid,
    input  logic                  i_sum_ready,
    output logic [DATA_WIDTH:0]   o_sum,
    output logic                  o_sum_id,
    output logic                  o_busy
);

    localparam int CNT_W = cnt_width(DATA_WIDTH);

    state_t                state;
    state_t                state_nxt;
    logic                  last_id;
    logic                  grant;
    logic                  any_valid;
    logic                  accept;
    logic                  last_bit;
    logic [DATA_WIDTH-1:0] sh_a;
    logic [DATA_WIDTH-1:0] sh_b;
    logic [DATA_WIDTH-1:0] res;
    logic [DATA_WIDTH:0]   res_ext;
    logic                  carry;
    logic [CNT_W-1:0]      cnt;
    logic                  op_id;
    logic [DATA_WIDTH:0]   sum_q;
    logic                  fa_sum;
    logic                  fa_cout;

    Full_adder u_fa (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // On a tie the requester not served last wins; a lone requester always wins.
    always_comb begin
        grant = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            grant = ~last_id;
        end else if (i_req1_valid) begin
            grant = 1'b1;
        end
    end

    assign any_valid = i_req0_valid | i_req1_valid;
    assign accept    = (o_req0_ready & i_req0_valid) | (o_req1_ready & i_req1_valid);
    assign last_bit  = (cnt == CNT_W'(DATA_WIDTH - 1));
    assign res_ext   = {fa_sum, res};

    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)      state_nxt = ST_RUN;
            ST_RUN:  if (last_bit)    state_nxt = ST_DONE;
            ST_DONE: if (i_sum_ready) state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // Ready is gated by reset so nothing can look granted while the FSM is held.
    always_comb begin
        o_req0_ready = s_rst && (state == ST_IDLE) && any_valid && (grant == 1'b0);
        o_req1_ready = s_rst && (state == ST_IDLE) && any_valid && (grant == 1'b1);
        o_busy       = (state == ST_RUN) || (state == ST_DONE);
        o_sum_valid  = (state == ST_DONE);
    end

    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            sh_a    <= '0;
            sh_b    <= '0;
            res     <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            op_id   <= 1'b0;
            sum_q   <= '0;
            last_id <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sh_a  <= grant ? i_req1_a : i_req0_a;
                        sh_b  <= grant ? i_req1_b : i_req0_b;
                        res   <= '0;
                        carry <= 1'b0;
                        cnt   <= '0;
                        op_id <= grant;
                    end
                end
                ST_RUN: begin
                    // Sum bits enter at the top so the first bit ends up at bit 0.
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    res   <= res_ext[DATA_WIDTH:1];
                    carry <= fa_cout;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        sum_q <= {fa_cout, res_ext[DATA_WIDTH:1]};
                    end
                end
                ST_DONE: begin
                    if (i_sum_ready) begin
                        last_id <= op_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_sum    = sum_q;
    assign o_sum_id = op_id;

endmodule
